// File: rtl/gb80_pkg.sv
// Shared definitions for the gb80 CPU sequencer: state encoding, T-state
// constants, default instruction/dispatch lengths and the effective-length helper.
package gb80_pkg;

  localparam int unsigned T_W = 2;
  localparam int unsigned M_W = 3;

  localparam int unsigned MAX_MCYC_DEF = 6;
  localparam int unsigned INT_MCYC_DEF = 5;

  localparam logic [T_W-1:0] T_1 = 2'd0;
  localparam logic [T_W-1:0] T_2 = 2'd1;
  localparam logic [T_W-1:0] T_3 = 2'd2;
  localparam logic [T_W-1:0] T_4 = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH        = 3'd0,
    ST_EXEC         = 3'd1,
    ST_CB_FETCH     = 3'd2,
    ST_INT_DISPATCH = 3'd3,
    ST_HALT         = 3'd4,
    ST_STOP         = 3'd5
  } seq_state_e;

  // Clamp the decoder's M-cycle count into 1..max_len.
  function automatic logic [M_W-1:0] eff_len(input logic [M_W-1:0] n,
                                             input int unsigned  max_len);
    logic [M_W-1:0] len;
    if (n == '0) begin
      len = M_W'(1);
    end else if (32'(n) > max_len) begin
      len = M_W'(max_len);
    end else begin
      len = n;
    end
    return len;
  endfunction

endpackage

// File: rtl/gb80_tcounter.sv
// Mod-4 T-state counter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   ce          advance enable (T-state increments when high)
//   t_state     current T-state, T1..T4 encoded 0..3
//   boundary_c  high on an enabled tick at T4 (end of the M-cycle)
module gb80_tcounter
  import gb80_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic [T_W-1:0] t_state,
  output logic           boundary_c
);

  // T-state register, wraps T4 -> T1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T_1;
    end else if (ce) begin
      t_state <= t_state + T_W'(1);
    end
  end

  assign boundary_c = ce && (t_state == T_4);

endmodule

// File: rtl/cpu_sequencer.sv
// gb80 CPU sequencer: tracks T-states and M-cycles, sequences opcode fetch,
// execute, CB-prefixed fetch, interrupt dispatch, HALT and STOP.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ce                T-state advance enable
//   dec_mcycles       instruction length in M-cycles from the decoder
//   dec_cb_prefix     fetched opcode is 0xCB
//   dec_halt/dec_stop fetched opcode is HALT / STOP
//   cond_fail         branch condition false, end instruction now
//   int_pending, ime  interrupt request and master enable
//   wake              joypad wake from STOP
//   t_state, m_cycle  current T-state and M-cycle index
//   fetch, ir_load    opcode-fetch M-cycle flag, IR load pulse
//   cb_mode           instruction is CB-prefixed
//   int_ack           interrupt acknowledge pulse
//   halted, stopped   in HALT / STOP
module cpu_sequencer
  import gb80_pkg::*;
#(
  parameter int unsigned MAX_MCYC = MAX_MCYC_DEF,
  parameter int unsigned INT_MCYC = INT_MCYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic [M_W-1:0] dec_mcycles,
  input  logic           dec_cb_prefix,
  input  logic           dec_halt,
  input  logic           dec_stop,
  input  logic           cond_fail,
  input  logic           int_pending,
  input  logic           ime,
  input  logic           wake,
  output logic [T_W-1:0] t_state,
  output logic [M_W-1:0] m_cycle,
  output logic           fetch,
  output logic           ir_load,
  output logic           cb_mode,
  output logic           int_ack,
  output logic           halted,
  output logic           stopped
);

  seq_state_e     state_q, state_d;
  logic [M_W-1:0] m_q, m_d;
  logic           cb_q, cb_d;
  logic           ir_load_q, ir_load_d;
  logic           int_ack_q, int_ack_d;
  logic           fetch_q, halted_q, stopped_q;
  logic           tick_en_c;
  logic           boundary_c;
  logic           instr_end_c;
  logic [M_W-1:0] len_c;

  // T-state is frozen while stopped
  assign tick_en_c = ce && (state_q != ST_STOP);

  gb80_tcounter u_tcounter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (tick_en_c),
    .t_state    (t_state),
    .boundary_c (boundary_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      m_q       <= '0;
      cb_q      <= 1'b0;
      ir_load_q <= 1'b0;
      int_ack_q <= 1'b0;
      fetch_q   <= 1'b1;
      halted_q  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      cb_q      <= cb_d;
      ir_load_q <= ir_load_d;
      int_ack_q <= int_ack_d;
      fetch_q   <= (state_d == ST_FETCH) || (state_d == ST_CB_FETCH);
      halted_q  <= (state_d == ST_HALT);
      stopped_q <= (state_d == ST_STOP);
    end
  end

  // Next-state logic; decoder and interrupt inputs only matter at M-boundaries
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    cb_d        = cb_q;
    ir_load_d   = 1'b0;
    int_ack_d   = 1'b0;
    instr_end_c = 1'b0;
    len_c       = eff_len(dec_mcycles, MAX_MCYC);

    if (boundary_c) begin
      case (state_q)
        ST_FETCH: begin
          ir_load_d = 1'b1;
          if (dec_stop) begin
            state_d = ST_STOP;
            m_d     = '0;
          end else if (dec_halt) begin
            state_d = ST_HALT;
            m_d     = '0;
          end else if (dec_cb_prefix) begin
            state_d = ST_CB_FETCH;
            m_d     = M_W'(1);
            cb_d    = 1'b1;
          end else if (len_c == M_W'(1)) begin
            instr_end_c = 1'b1;
          end else begin
            state_d = ST_EXEC;
            m_d     = M_W'(1);
          end
        end
        ST_EXEC, ST_CB_FETCH: begin
          ir_load_d = (state_q == ST_CB_FETCH);
          // >= covers a CB opcode whose decoded length is shorter than the prefix
          if ((m_q >= len_c - M_W'(1)) || cond_fail) begin
            instr_end_c = 1'b1;
          end else begin
            state_d = ST_EXEC;
            m_d     = m_q + M_W'(1);
          end
        end
        ST_INT_DISPATCH: begin
          int_ack_d = (m_q == M_W'(2));
          if (m_q == M_W'(INT_MCYC - 1)) begin
            state_d = ST_FETCH;
            m_d     = '0;
          end else begin
            m_d = m_q + M_W'(1);
          end
        end
        ST_HALT: begin
          if (int_pending) begin
            state_d = ime ? ST_INT_DISPATCH : ST_FETCH;
            m_d     = '0;
          end
        end
        default: begin
        end
      endcase

      if (instr_end_c) begin
        state_d = (int_pending && ime) ? ST_INT_DISPATCH : ST_FETCH;
        m_d     = '0;
        cb_d    = 1'b0;
      end
    end

    // STOP never sees a boundary; wake is checked on every enabled tick
    if ((state_q == ST_STOP) && ce && wake) begin
      state_d = ST_FETCH;
      m_d     = '0;
    end
  end

  assign m_cycle = m_q;
  assign fetch   = fetch_q;
  assign ir_load = ir_load_q;
  assign cb_mode = cb_q;
  assign int_ack = int_ack_q;
  assign halted  = halted_q;
  assign stopped = stopped_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: NOP stream, multi-cycle and conditional
// instructions, CB prefix, interrupt dispatch, HALT, STOP, reset and ce stretch.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [2:0] dec_mcycles;
  logic       dec_cb_prefix;
  logic       dec_halt;
  logic       dec_stop;
  logic       cond_fail;
  logic       int_pending;
  logic       ime;
  logic       wake;
  logic [1:0] t_state;
  logic [2:0] m_cycle;
  logic       fetch;
  logic       ir_load;
  logic       cb_mode;
  logic       int_ack;
  logic       halted;
  logic       stopped;

  int vec_cnt;
  int miscmp_cnt;
  int ack_cnt;

  cpu_sequencer #(.MAX_MCYC(6), .INT_MCYC(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .dec_mcycles   (dec_mcycles),
    .dec_cb_prefix (dec_cb_prefix),
    .dec_halt      (dec_halt),
    .dec_stop      (dec_stop),
    .cond_fail     (cond_fail),
    .int_pending   (int_pending),
    .ime           (ime),
    .wake          (wake),
    .t_state       (t_state),
    .m_cycle       (m_cycle),
    .fetch         (fetch),
    .ir_load       (ir_load),
    .cb_mode       (cb_mode),
    .int_ack       (int_ack),
    .halted        (halted),
    .stopped       (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscmp_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vec_cnt       = 0;
    miscmp_cnt    = 0;
    ack_cnt       = 0;
    rst_n         = 1'b0;
    ce            = 1'b1;
    dec_mcycles   = 3'd1;
    dec_cb_prefix = 1'b0;
    dec_halt      = 1'b0;
    dec_stop      = 1'b0;
    cond_fail     = 1'b0;
    int_pending   = 1'b0;
    ime           = 1'b0;
    wake          = 1'b0;

    // Reset state
    ticks(2);
    chk("rst_t", t_state, 0);
    chk("rst_m", m_cycle, 0);
    chk("rst_fetch", fetch, 1);
    chk("rst_flags", {ir_load, cb_mode, int_ack, halted, stopped}, 0);
    rst_n = 1'b1;

    // NOP x3: ir_load every 4 clocks, m_cycle stays 0
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("nop_t", t_state, i % 4);
      chk("nop_m", m_cycle, 0);
      chk("nop_ir", ir_load, (i % 4 == 0) ? 1 : 0);
    end

    // L=3 runs m_cycle 0,1,2 then returns to FETCH
    dec_mcycles = 3'd3;
    ticks(4);
    chk("l3_m1", m_cycle, 1);
    chk("l3_fetch1", fetch, 0);
    ticks(4);
    chk("l3_m2", m_cycle, 2);
    chk("l3_ir2", ir_load, 0);
    ticks(4);
    chk("l3_end_m", m_cycle, 0);
    chk("l3_end_fetch", fetch, 1);

    // cond_fail ignored in FETCH, ends instruction in m_cycle 1
    cond_fail = 1'b1;
    ticks(4);
    chk("cf_fetch_ign_m", m_cycle, 1);
    chk("cf_fetch_ign_f", fetch, 0);
    ticks(4);
    chk("cf_end_m", m_cycle, 0);
    chk("cf_end_fetch", fetch, 1);
    cond_fail = 1'b0;

    // 0xCB then L=4
    dec_cb_prefix = 1'b1;
    dec_mcycles   = 3'd4;
    ticks(4);
    chk("cb_ir4", ir_load, 1);
    chk("cb_mode5", cb_mode, 1);
    chk("cb_fetch5", fetch, 1);
    chk("cb_m1", m_cycle, 1);
    dec_cb_prefix = 1'b0;
    ticks(4);
    chk("cb_ir8", ir_load, 1);
    chk("cb_exec_m2", m_cycle, 2);
    chk("cb_exec_fetch", fetch, 0);
    ticks(4);
    chk("cb_m3", m_cycle, 3);
    chk("cb_mode13", cb_mode, 1);
    ticks(4);
    chk("cb_mode17", cb_mode, 0);
    chk("cb_fetch17", fetch, 1);
    chk("cb_m17", m_cycle, 0);

    // Interrupt at the last boundary of L=2
    dec_mcycles = 3'd2;
    ime         = 1'b1;
    int_pending = 1'b1;
    ticks(4);
    chk("int_l2_m1", m_cycle, 1);
    ticks(4);
    chk("int_enter_m", m_cycle, 0);
    chk("int_enter_fetch", fetch, 0);
    for (int d = 1; d <= 20; d++) begin
      tick();
      if (int_ack) ack_cnt++;
      chk("int_ack", int_ack, (d == 12) ? 1 : 0);
      chk("int_m", m_cycle, (d == 20) ? 0 : d / 4);
      chk("int_fetch", fetch, (d == 20) ? 1 : 0);
    end
    chk("int_ack_count", ack_cnt, 1);
    int_pending = 1'b0;
    ime         = 1'b0;
    dec_mcycles = 3'd1;

    // HALT, then int_pending with ime=0 returns to FETCH without int_ack
    dec_halt = 1'b1;
    ticks(4);
    chk("halt_enter", halted, 1);
    chk("halt_ir", ir_load, 1);
    chk("halt_fetch", fetch, 0);
    dec_halt = 1'b0;
    ticks(2);
    chk("halt_t_cycles", t_state, 2);
    ticks(2);
    chk("halt_stay", halted, 1);
    chk("halt_m", m_cycle, 0);
    int_pending = 1'b1;
    ticks(3);
    chk("halt_wait", halted, 1);
    tick();
    chk("halt_exit", halted, 0);
    chk("halt_exit_fetch", fetch, 1);
    chk("halt_no_ack", int_ack, 0);
    int_pending = 1'b0;

    // STOP wins over HALT; t_state held at 0 until wake
    dec_stop = 1'b1;
    dec_halt = 1'b1;
    ticks(4);
    chk("stop_enter", stopped, 1);
    chk("stop_not_halt", halted, 0);
    dec_stop = 1'b0;
    dec_halt = 1'b0;
    ticks(6);
    chk("stop_t_held", t_state, 0);
    chk("stop_stay", stopped, 1);
    wake = 1'b1;
    tick();
    chk("wake_exit", stopped, 0);
    chk("wake_fetch", fetch, 1);
    chk("wake_t", t_state, 0);
    wake = 1'b0;
    tick();
    chk("wake_t1", t_state, 1);
    ticks(3);
    chk("wake_nop_ir", ir_load, 1);
    chk("wake_nop_t", t_state, 0);

    // ce toggling stretches timing 2x; reset mid-EXEC aborts at once
    dec_mcycles = 3'd4;
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; tick();
      ce = 1'b0; tick();
    end
    chk("ce2x_m1", m_cycle, 1);
    chk("ce2x_t0", t_state, 0);
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; tick();
      ce = 1'b0; tick();
    end
    chk("ce2x_m2", m_cycle, 2);
    ce = 1'b1; tick();
    chk("ce2x_t1", t_state, 1);
    ce = 1'b0; tick();
    chk("ce2x_t_hold", t_state, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_t", t_state, 0);
    chk("arst_m", m_cycle, 0);
    chk("arst_fetch", fetch, 1);
    chk("arst_ack", int_ack, 0);
    #2;
    rst_n       = 1'b1;
    ce          = 1'b1;
    dec_mcycles = 3'd1;
    tick();
    chk("post_rst_t1", t_state, 1);
    chk("post_rst_fetch", fetch, 1);
    ticks(3);
    chk("post_rst_ir", ir_load, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
